// File: rtl/fnd_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scan driver.
// Exports: SEG_W, SEG_BLANK, MAX_DIG, scan_st_e {ST_GUARD, ST_ON}, enb_vec().
package fnd_pkg;

  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = '0;
  localparam int MAX_DIG = 8;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_ON    = 1'b1
  } scan_st_e;

  // One-hot enable for digit idx, inverted for active-low boards.
  function automatic logic [MAX_DIG-1:0] enb_vec(
    input logic [2:0] idx,
    input logic       act_low
  );
    logic [MAX_DIG-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return act_low ? ~v : v;
  endfunction

endpackage

// File: rtl/fnd_slot_timer.sv
// Slot/digit/frame/blink counter chain plus the per-slot GUARD/ON state machine.
// Ports: clk, rst | dig_idx_o, blink_ph_o, guard_o, slot_end_o, frame_end_o, frame_st_o.
module fnd_slot_timer
  import fnd_pkg::*;
#(
  parameter int NUM_DIG   = 6,
  parameter int TICK_DIV  = 5000,
  parameter int GUARD_CYC = 16,
  parameter int BLINK_DIV = 64,
  localparam int DW = $clog2(NUM_DIG)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [DW-1:0] dig_idx_o,
  output logic          blink_ph_o,
  output logic          guard_o,
  output logic          slot_end_o,
  output logic          frame_end_o,
  output logic          frame_st_o
);

  localparam int SW = $clog2(TICK_DIV);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(TICK_DIV - 1);
  localparam logic [SW-1:0] GUARD_LAST = SW'(GUARD_CYC - 1);
  localparam logic [DW-1:0] DIG_LAST   = DW'(NUM_DIG - 1);
  localparam logic [FW-1:0] FRM_LAST   = FW'(BLINK_DIV - 1);

  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic [DW-1:0] dig_idx_q, dig_idx_d;
  logic [FW-1:0] frm_cnt_q, frm_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  scan_st_e      st_q, st_d;

  logic slot_end;
  logic frame_end;
  logic blink_wrap;

  always_comb begin
    slot_end   = (slot_cnt_q == SLOT_LAST);
    frame_end  = slot_end && (dig_idx_q == DIG_LAST);
    blink_wrap = frame_end && (frm_cnt_q == FRM_LAST);

    slot_cnt_d = slot_end ? '0 : slot_cnt_q + 1'b1;

    dig_idx_d = dig_idx_q;
    if (slot_end) begin
      dig_idx_d = (dig_idx_q == DIG_LAST) ? '0 : dig_idx_q + 1'b1;
    end

    frm_cnt_d = frm_cnt_q;
    if (frame_end) begin
      frm_cnt_d = (frm_cnt_q == FRM_LAST) ? '0 : frm_cnt_q + 1'b1;
    end

    blink_ph_d = blink_ph_q ^ blink_wrap;
  end

  // GUARD covers slot cycles 0..GUARD_CYC-1; every slot restarts in GUARD.
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_GUARD: begin
        if (slot_end) begin
          st_d = ST_GUARD;
        end else if (slot_cnt_q == GUARD_LAST) begin
          st_d = ST_ON;
        end
      end
      ST_ON: begin
        if (slot_end) begin
          st_d = ST_GUARD;
        end
      end
      default: st_d = ST_GUARD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_q <= '0;
      dig_idx_q  <= '0;
      frm_cnt_q  <= '0;
      blink_ph_q <= 1'b0;
      st_q       <= ST_GUARD;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      dig_idx_q  <= dig_idx_d;
      frm_cnt_q  <= frm_cnt_d;
      blink_ph_q <= blink_ph_d;
      st_q       <= st_d;
    end
  end

  assign dig_idx_o   = dig_idx_q;
  assign blink_ph_o  = blink_ph_q;
  assign guard_o     = (st_q == ST_GUARD);
  assign slot_end_o  = slot_end;
  assign frame_end_o = frame_end;
  assign frame_st_o  = (slot_cnt_q == '0) && (dig_idx_q == '0);

endmodule

// File: rtl/fnd_scan_disp.sv
// Multiplexed seven-segment scan driver: staging/shadow frame buffers, update handshake, output regs.
// Ports: clk, rst, i_dig_seg, i_dig_dp, i_blink_msk, i_upd | o_upd_ack, o_seg, o_seg_dp, o_seg_enb, o_frame_st.
module fnd_scan_disp
  import fnd_pkg::*;
#(
  parameter int NUM_DIG     = 6,
  parameter int TICK_DIV    = 5000,
  parameter int GUARD_CYC   = 16,
  parameter int BLINK_DIV   = 64,
  parameter int ENB_ACT_LOW = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_DIG*SEG_W-1:0] i_dig_seg,
  input  logic [NUM_DIG-1:0]       i_dig_dp,
  input  logic [NUM_DIG-1:0]       i_blink_msk,
  input  logic                     i_upd,
  output logic                     o_upd_ack,
  output logic [SEG_W-1:0]         o_seg,
  output logic                     o_seg_dp,
  output logic [NUM_DIG-1:0]       o_seg_enb,
  output logic                     o_frame_st
);

  localparam int DW = $clog2(NUM_DIG);
  localparam logic ACT_LOW = (ENB_ACT_LOW != 0);
  localparam logic [NUM_DIG-1:0] ENB_OFF =
    ACT_LOW ? {NUM_DIG{1'b1}} : {NUM_DIG{1'b0}};

  logic [DW-1:0] dig_idx;
  logic          blink_ph;
  logic          guard;
  logic          slot_end;
  logic          frame_end;
  logic          frame_st;

  fnd_slot_timer #(
    .NUM_DIG   (NUM_DIG),
    .TICK_DIV  (TICK_DIV),
    .GUARD_CYC (GUARD_CYC),
    .BLINK_DIV (BLINK_DIV)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .dig_idx_o   (dig_idx),
    .blink_ph_o  (blink_ph),
    .guard_o     (guard),
    .slot_end_o  (slot_end),
    .frame_end_o (frame_end),
    .frame_st_o  (frame_st)
  );

  logic [NUM_DIG-1:0][SEG_W-1:0] stg_seg_q, stg_seg_d;
  logic [NUM_DIG-1:0]            stg_dp_q, stg_dp_d;
  logic [NUM_DIG-1:0]            stg_blk_q, stg_blk_d;
  logic [NUM_DIG-1:0][SEG_W-1:0] shd_seg_q, shd_seg_d;
  logic [NUM_DIG-1:0]            shd_dp_q, shd_dp_d;
  logic [NUM_DIG-1:0]            shd_blk_q, shd_blk_d;
  logic                          pend_q, pend_d;

  logic [SEG_W-1:0]   seg_q, seg_d;
  logic               dp_q, dp_d;
  logic [NUM_DIG-1:0] enb_q, enb_d;
  logic               ack_q, ack_d;
  logic               fst_q, fst_d;

  logic               bnd;
  logic               load;
  logic               blank;
  logic [MAX_DIG-1:0] enb_full;

  always_comb begin
    bnd  = slot_end & frame_end;
    load = bnd & pend_q;

    stg_seg_d = stg_seg_q;
    stg_dp_d  = stg_dp_q;
    stg_blk_d = stg_blk_q;
    if (i_upd) begin
      stg_seg_d = i_dig_seg;
      stg_dp_d  = i_dig_dp;
      stg_blk_d = i_blink_msk;
    end

    // Shadow moves only on the frame boundary, so a frame is never torn.
    // An i_upd on the boundary itself keeps pend set for the next frame.
    shd_seg_d = load ? stg_seg_q : shd_seg_q;
    shd_dp_d  = load ? stg_dp_q  : shd_dp_q;
    shd_blk_d = load ? stg_blk_q : shd_blk_q;
    pend_d    = i_upd | (pend_q & ~bnd);

    ack_d = load;
    fst_d = frame_st;

    enb_full = enb_vec(3'(dig_idx), ACT_LOW);
    blank    = shd_blk_q[dig_idx] & blink_ph;

    enb_d = ENB_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b0;
    if (!guard) begin
      enb_d = enb_full[NUM_DIG-1:0];
      if (!blank) begin
        seg_d = shd_seg_q[dig_idx];
        dp_d  = shd_dp_q[dig_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_seg_q <= '0;
      stg_dp_q  <= '0;
      stg_blk_q <= '0;
      shd_seg_q <= '0;
      shd_dp_q  <= '0;
      shd_blk_q <= '0;
      pend_q    <= 1'b0;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b0;
      enb_q     <= ENB_OFF;
      ack_q     <= 1'b0;
      fst_q     <= 1'b0;
    end else begin
      stg_seg_q <= stg_seg_d;
      stg_dp_q  <= stg_dp_d;
      stg_blk_q <= stg_blk_d;
      shd_seg_q <= shd_seg_d;
      shd_dp_q  <= shd_dp_d;
      shd_blk_q <= shd_blk_d;
      pend_q    <= pend_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      enb_q     <= enb_d;
      ack_q     <= ack_d;
      fst_q     <= fst_d;
    end
  end

  assign o_seg      = seg_q;
  assign o_seg_dp   = dp_q;
  assign o_seg_enb  = enb_q;
  assign o_upd_ack  = ack_q;
  assign o_frame_st = fst_q;

endmodule

// File: tb/tb_fnd_scan_disp.sv
// Self-checking bench for fnd_scan_disp (3 digits, 8-cycle slots, 2-cycle guard).
// Per-cycle expected outputs come from a time-indexed model via a scoreboard queue.
module tb_fnd_scan_disp;

  localparam int ND = 3;
  localparam int TD = 8;
  localparam int GC = 2;
  localparam int BD = 2;
  localparam int FL = TD * ND;

  logic          clk;
  logic          rst;
  logic [ND*7-1:0] i_dig_seg;
  logic [ND-1:0] i_dig_dp;
  logic [ND-1:0] i_blink_msk;
  logic          i_upd;
  logic          o_upd_ack;
  logic [6:0]    o_seg;
  logic          o_seg_dp;
  logic [ND-1:0] o_seg_enb;
  logic          o_frame_st;

  fnd_scan_disp #(
    .NUM_DIG     (ND),
    .TICK_DIV    (TD),
    .GUARD_CYC   (GC),
    .BLINK_DIV   (BD),
    .ENB_ACT_LOW (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_dig_seg   (i_dig_seg),
    .i_dig_dp    (i_dig_dp),
    .i_blink_msk (i_blink_msk),
    .i_upd       (i_upd),
    .o_upd_ack   (o_upd_ack),
    .o_seg       (o_seg),
    .o_seg_dp    (o_seg_dp),
    .o_seg_enb   (o_seg_enb),
    .o_frame_st  (o_frame_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]    seg;
    logic          dp;
    logic [ND-1:0] enb;
    logic          ack;
    logic          fst;
  } exp_t;

  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position in the scan derived from cycles since reset.
  int              t;
  logic [ND-1:0][6:0] m_stg_seg, m_shd_seg;
  logic [ND-1:0]   m_stg_dp, m_shd_dp;
  logic [ND-1:0]   m_stg_blk, m_shd_blk;
  logic            m_pend;

  always @(posedge clk) begin
    int   slot, dig, frm, ph;
    logic last;
    logic [ND-1:0] one;
    exp_t e;
    if (rst) begin
      t = 0;
      m_stg_seg = '0; m_shd_seg = '0;
      m_stg_dp = '0;  m_shd_dp = '0;
      m_stg_blk = '0; m_shd_blk = '0;
      m_pend = 1'b0;
    end else begin
      one  = 1;
      slot = t % TD;
      dig  = (t / TD) % ND;
      frm  = t / FL;
      ph   = (frm / BD) % 2;
      last = (slot == TD - 1) && (dig == ND - 1);
      e.fst = (slot == 0) && (dig == 0);
      e.ack = last && m_pend;
      if (slot < GC) begin
        e.enb = '1;
        e.seg = '0;
        e.dp  = 1'b0;
      end else begin
        e.enb = ~(one << dig);
        if (m_shd_blk[dig] && ph == 1) begin
          e.seg = '0;
          e.dp  = 1'b0;
        end else begin
          e.seg = m_shd_seg[dig];
          e.dp  = m_shd_dp[dig];
        end
      end
      sbq.push_back(e);
      if (last && m_pend) begin
        m_shd_seg = m_stg_seg;
        m_shd_dp  = m_stg_dp;
        m_shd_blk = m_stg_blk;
      end
      m_pend = i_upd ? 1'b1 : (last ? 1'b0 : m_pend);
      if (i_upd) begin
        m_stg_seg = i_dig_seg;
        m_stg_dp  = i_dig_dp;
        m_stg_blk = i_blink_msk;
      end
      t++;
    end
  end

  int cyc = 0;
  int ack_cnt = 0;
  int ack_last = 0;
  int ack_prev = 0;
  int fst_last = -1;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      fst_last = -1;
    end else if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("seg", 32'(o_seg), 32'(e.seg));
      chk("dp", 32'(o_seg_dp), 32'(e.dp));
      chk("enb", 32'(o_seg_enb), 32'(e.enb));
      chk("ack", 32'(o_upd_ack), 32'(e.ack));
      chk("fst", 32'(o_frame_st), 32'(e.fst));
      if (o_upd_ack) begin
        ack_cnt++;
        ack_prev = ack_last;
        ack_last = cyc;
      end
      if (o_frame_st) begin
        if (fst_last >= 0) chk("fper", 32'(cyc - fst_last), 32'(FL));
        fst_last = cyc;
      end
    end
  end

  task automatic upd(input logic [ND*7-1:0] seg, input logic [ND-1:0] dp,
                     input logic [ND-1:0] blk);
    i_dig_seg   = seg;
    i_dig_dp    = dp;
    i_blink_msk = blk;
    i_upd       = 1'b1;
    @(negedge clk);
    i_upd = 1'b0;
  endtask

  task automatic wait_fst();
    int n = 0;
    @(negedge clk);
    while (!o_frame_st && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("to_fst", 32'(o_frame_st), 32'd1);
  endtask

  task automatic chk_rst_outs();
    chk("rst_enb", 32'(o_seg_enb), 32'h7);
    chk("rst_seg", 32'(o_seg), 32'h0);
    chk("rst_dp", 32'(o_seg_dp), 32'h0);
    chk("rst_ack", 32'(o_upd_ack), 32'h0);
    chk("rst_fst", 32'(o_frame_st), 32'h0);
  endtask

  int base;

  initial begin
    int n;
    rst = 1'b1;
    i_upd = 1'b0;
    i_dig_seg = '0;
    i_dig_dp = '0;
    i_blink_msk = '0;
    repeat (3) @(negedge clk);
    chk_rst_outs();
    rst = 1'b0;

    // First update right after release: acked at frame 1 start.
    upd({7'h30, 7'h6D, 7'h7E}, 3'b101, 3'b000);
    repeat (2 * FL) @(negedge clk);
    #1 chk("ack1", 32'(ack_cnt), 32'd1);

    // Blink on digit 1 across a full blink period.
    upd({7'h06, 7'h5B, 7'h4F}, 3'b010, 3'b010);
    repeat (5 * FL) @(negedge clk);

    // Two updates in one frame: single ack, last data wins.
    wait_fst();
    base = ack_cnt;
    upd({7'h11, 7'h22, 7'h33}, 3'b001, 3'b000);
    repeat (3) @(negedge clk);
    upd({7'h44, 7'h55, 7'h66}, 3'b100, 3'b000);
    repeat (2 * FL) @(negedge clk);
    #1 chk("ack_lastwins", 32'(ack_cnt - base), 32'd1);

    // Update landing exactly on the boundary cycle.
    wait_fst();
    base = ack_cnt;
    upd({7'h01, 7'h02, 7'h03}, 3'b000, 3'b000);
    repeat (FL - 3) @(negedge clk);
    upd({7'h7F, 7'h40, 7'h08}, 3'b111, 3'b000);
    repeat (3 * FL) @(negedge clk);
    #1;
    chk("ack_bnd_cnt", 32'(ack_cnt - base), 32'd2);
    chk("ack_bnd_gap", 32'(ack_last - ack_prev), 32'(FL));

    // Reset mid-ON with an update still pending: it must be dropped.
    wait_fst();
    upd({7'h3F, 7'h3F, 7'h3F}, 3'b111, 3'b000);
    n = 0;
    while (o_seg_enb == 3'b111 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("to_on", 32'(o_seg_enb != 3'b111), 32'd1);
    #2 rst = 1'b1;
    sbq.delete();
    #1 chk_rst_outs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    base = ack_cnt;
    repeat (3 * FL) @(negedge clk);
    #1 chk("ack_drop", 32'(ack_cnt - base), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
